// File: rtl/proc_ctrl.sv
// proc_ctrl: multicycle processor control FSM driving register, bus, ALU and memory strobes.
// Define ILLEGAL_TRAP_EN to trap opcode 111 into a HALT state with a sticky Illegal flag.
module proc_ctrl (
    input  logic       Clock,
    input  logic       Resetn,
    input  logic       Run,
    input  logic [8:0] IR,
    input  logic       Gnz,
    output logic [7:0] Rin,
    output logic [7:0] Rout,
    output logic       Gout,
    output logic       DINout,
    output logic       Ain,
    output logic       Gin,
    output logic       IRin,
    output logic       ADDRin,
    output logic       DOUTin,
    output logic       PCincr,
    output logic       W_D,
    output logic       AddSub,
    output logic       Done
`ifdef ILLEGAL_TRAP_EN
    ,
    output logic       Illegal
`endif
);
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] FETCH  = 3'd1;
    localparam logic [2:0] WAIT   = 3'd2;
    localparam logic [2:0] LOADIR = 3'd3;
    localparam logic [2:0] EX1    = 3'd4;
    localparam logic [2:0] EX2    = 3'd5;
    localparam logic [2:0] EX3    = 3'd6;
`ifdef ILLEGAL_TRAP_EN
    localparam logic [2:0] HALT   = 3'd7;
    localparam logic [2:0] OP_ILL = 3'b111;
`endif
    localparam logic [2:0] OP_MV   = 3'b000;
    localparam logic [2:0] OP_MVI  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_LD   = 3'b100;
    localparam logic [2:0] OP_ST   = 3'b101;
    localparam logic [2:0] OP_MVNZ = 3'b110;

    logic [2:0] state, nxt;
    logic [2:0] op;
    logic [7:0] x_oh, y_oh;

    assign op   = IR[8:6];
    assign x_oh = 8'b1 << IR[5:3];
    assign y_oh = 8'b1 << IR[2:0];

    // Strobes depend only on state, IR and Gnz so Run can never glitch them.
    always_comb begin
        Rin    = '0;
        Rout   = '0;
        Gout   = 1'b0;
        DINout = 1'b0;
        Ain    = 1'b0;
        Gin    = 1'b0;
        IRin   = 1'b0;
        ADDRin = 1'b0;
        DOUTin = 1'b0;
        PCincr = 1'b0;
        W_D    = 1'b0;
        AddSub = 1'b0;
        Done   = 1'b0;
        case (state)
            FETCH: begin
                Rout   = 8'h80;
                ADDRin = 1'b1;
                PCincr = 1'b1;
            end
            LOADIR: IRin = 1'b1;
            EX1: begin
                case (op)
                    OP_MV: begin
                        Rout = y_oh;
                        Rin  = x_oh;
                        Done = 1'b1;
                    end
                    OP_MVI: begin
                        Rout   = 8'h80;
                        ADDRin = 1'b1;
                        PCincr = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        Rout = x_oh;
                        Ain  = 1'b1;
                    end
                    OP_LD, OP_ST: begin
                        Rout   = y_oh;
                        ADDRin = 1'b1;
                    end
                    OP_MVNZ: begin
                        Rout = Gnz ? y_oh : 8'h00;
                        Rin  = Gnz ? x_oh : 8'h00;
                        Done = 1'b1;
                    end
                    default: begin
`ifndef ILLEGAL_TRAP_EN
                        Done = 1'b1;
`endif
                    end
                endcase
            end
            EX2: begin
                case (op)
                    OP_ADD, OP_SUB: begin
                        Rout   = y_oh;
                        Gin    = 1'b1;
                        AddSub = IR[6];
                    end
                    OP_ST: begin
                        Rout   = x_oh;
                        DOUTin = 1'b1;
                        W_D    = 1'b1;
                        Done   = 1'b1;
                    end
                    default: ;
                endcase
            end
            EX3: begin
                case (op)
                    OP_MVI, OP_LD: begin
                        DINout = 1'b1;
                        Rin    = x_oh;
                        Done   = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        Gout = 1'b1;
                        Rin  = x_oh;
                        Done = 1'b1;
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    // Run is consulted only in IDLE and in the Done cycle of an instruction.
    always_comb begin
        case (state)
            IDLE:    nxt = Run ? FETCH : IDLE;
            FETCH:   nxt = WAIT;
            WAIT:    nxt = LOADIR;
            LOADIR:  nxt = EX1;
`ifdef ILLEGAL_TRAP_EN
            EX1:     nxt = (op == OP_ILL) ? HALT : EX2;
            HALT:    nxt = HALT;
`else
            EX1:     nxt = EX2;
`endif
            EX2:     nxt = EX3;
            default: nxt = IDLE;
        endcase
        if (Done)
            nxt = Run ? FETCH : IDLE;
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn)
            state <= IDLE;
        else
            state <= nxt;
    end

`ifdef ILLEGAL_TRAP_EN
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn)
            Illegal <= 1'b0;
        else if (state == EX1 && op == OP_ILL)
            Illegal <= 1'b1;
    end
`endif
endmodule

// File: tb/tb_proc_ctrl.sv
// tb_proc_ctrl: directed and randomized checks of proc_ctrl against a per-cycle instruction model.
// Works with or without ILLEGAL_TRAP_EN defined.
module tb_proc_ctrl;
    logic       Clock = 1'b0;
    logic       Resetn, Run, Gnz;
    logic [8:0] IR;
    logic [7:0] Rin, Rout;
    logic       Gout, DINout, Ain, Gin, IRin, ADDRin, DOUTin, PCincr, W_D, AddSub, Done;
`ifdef ILLEGAL_TRAP_EN
    logic       Illegal;
`endif
    logic [26:0] outs;
    int total = 0;
    int passed = 0;
    int fails = 0;

    proc_ctrl dut (
        .Clock(Clock), .Resetn(Resetn), .Run(Run), .IR(IR), .Gnz(Gnz),
        .Rin(Rin), .Rout(Rout), .Gout(Gout), .DINout(DINout), .Ain(Ain), .Gin(Gin),
        .IRin(IRin), .ADDRin(ADDRin), .DOUTin(DOUTin), .PCincr(PCincr), .W_D(W_D),
        .AddSub(AddSub), .Done(Done)
`ifdef ILLEGAL_TRAP_EN
        , .Illegal(Illegal)
`endif
    );

    always #5 Clock = ~Clock;

    assign outs = {Rin, Rout, Gout, DINout, Ain, Gin, IRin, ADDRin, DOUTin, PCincr, W_D, AddSub, Done};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Instruction length in cycles counted from FETCH through the last cycle.
    function automatic int ilen(input logic [8:0] ir);
        case (ir[8:6])
            3'b000, 3'b110, 3'b111: return 4;
            3'b101:                 return 5;
            default:                return 6;
        endcase
    endfunction

    // Expected strobe vector in cycle k (0 = FETCH) of instruction ir.
    function automatic logic [26:0] model(input int k, input logic [8:0] ir, input logic gnz);
        logic [7:0] rin = '0, rout = '0;
        logic gout = 0, dinout = 0, ain = 0, gin = 0, irin = 0, addrin = 0;
        logic doutin = 0, pcincr = 0, wd = 0, addsub = 0, done = 0;
        int x = int'(ir[5:3]);
        int y = int'(ir[2:0]);
        int op = int'(ir[8:6]);
        if (k == 0) begin rout[7] = 1; addrin = 1; pcincr = 1; end
        if (k == 2) irin = 1;
        if (k == 3) begin
            if (op == 0) begin rout[y] = 1; rin[x] = 1; done = 1; end
            if (op == 1) begin rout[7] = 1; addrin = 1; pcincr = 1; end
            if (op == 2 || op == 3) begin rout[x] = 1; ain = 1; end
            if (op == 4 || op == 5) begin rout[y] = 1; addrin = 1; end
            if (op == 6) begin done = 1; if (gnz) begin rout[y] = 1; rin[x] = 1; end end
`ifndef ILLEGAL_TRAP_EN
            if (op == 7) done = 1;
`endif
        end
        if (k == 4) begin
            if (op == 2 || op == 3) begin rout[y] = 1; gin = 1; addsub = (op == 3); end
            if (op == 5) begin rout[x] = 1; doutin = 1; wd = 1; done = 1; end
        end
        if (k == 5) begin
            if (op == 1 || op == 4) begin dinout = 1; rin[x] = 1; done = 1; end
            if (op == 2 || op == 3) begin gout = 1; rin[x] = 1; done = 1; end
        end
        return {rin, rout, gout, dinout, ain, gin, irin, addrin, doutin, pcincr, wd, addsub, done};
    endfunction

    // Called just after the edge that enters FETCH; returns just after the edge after the last cycle.
    task automatic exec(input string name, input logic [8:0] ir, input logic gnz,
                        input int drop_k, input int rst_k);
        IR = ir;
        Gnz = gnz;
        for (int k = 0; k < ilen(ir); k++) begin
            @(negedge Clock);
            chk($sformatf("%s cyc%0d ir=%b", name, k, ir), 32'(outs), 32'(model(k, ir, gnz)));
            chk($sformatf("%s bus cyc%0d", name, k), 32'($countones({Rout, Gout, DINout}) <= 1), 32'd1);
            if (k == drop_k) Run = 1'b0;
            if (k == rst_k) begin
                Resetn = 1'b0;
                #1 chk($sformatf("%s reset cyc%0d", name, k), 32'(outs), 32'd0);
                return;
            end
            @(posedge Clock);
            #1;
        end
    endtask

    initial begin
        Resetn = 1'b1; Run = 1'b0; IR = '0; Gnz = 1'b0;
        #1 Resetn = 1'b0;
        #1 chk("reset outs", 32'(outs), 32'd0);
`ifdef ILLEGAL_TRAP_EN
        chk("reset illegal", 32'(Illegal), 32'd0);
`endif
        @(negedge Clock);
        Resetn = 1'b1;
        @(posedge Clock);
        #1 chk("idle run0", 32'(outs), 32'd0);
        Run = 1'b1;
        @(posedge Clock);
        #1;
        exec("mv r3,r5", 9'b000_011_101, 1'b0, -1, -1);
        exec("sub r1,r2", 9'b011_001_010, 1'b0, -1, -1);
        exec("mvnz gnz0", 9'b110_000_001, 1'b0, -1, -1);
        exec("mvnz gnz1", 9'b110_000_001, 1'b1, -1, -1);
        exec("add r7,r7", 9'b010_111_111, 1'b0, -1, -1);
        exec("st r4,[r6]", 9'b101_100_110, 1'b0, 3, -1);
        for (int i = 0; i < 3; i++) begin
            @(negedge Clock);
            chk($sformatf("idle after st %0d", i), 32'(outs), 32'd0);
        end
        Run = 1'b1;
        @(posedge Clock);
        #1;
        for (int i = 0; i < 40; i++) begin
            logic [8:0] r;
            r = 9'($urandom);
`ifdef ILLEGAL_TRAP_EN
            if (r[8:6] == 3'b111) r[8:6] = 3'b010;
`endif
            exec("rand", r, 1'($urandom), -1, -1);
        end
        exec("add abort", 9'b010_001_010, 1'b0, -1, 4);
        @(posedge Clock);
        #1 chk("held reset", 32'(outs), 32'd0);
        Resetn = 1'b1;
        @(negedge Clock);
        chk("idle after reset", 32'(outs), 32'd0);
        @(posedge Clock);
        #1;
        exec("ld r2,[r7]", 9'b100_010_111, 1'b0, -1, -1);
        exec("mvi r7", 9'b001_111_000, 1'b1, -1, -1);
`ifdef ILLEGAL_TRAP_EN
        exec("illegal", 9'b111_010_011, 1'b1, -1, -1);
        for (int i = 0; i < 10; i++) begin
            @(negedge Clock);
            chk($sformatf("halt outs %0d", i), 32'(outs), 32'd0);
            chk($sformatf("halt illegal %0d", i), 32'(Illegal), 32'd1);
        end
        Resetn = 1'b0;
        #1 chk("illegal cleared", 32'(Illegal), 32'd0);
        Resetn = 1'b1;
        @(posedge Clock);
`else
        exec("nop 111", 9'b111_010_011, 1'b1, -1, -1);
        exec("mv after nop", 9'b000_001_111, 1'b0, -1, -1);
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/proc_ctrl.md
PROC_CTRL -- requirements
Module: proc_ctrl

Interface
REQ-001 Clock  in  1  sole clock; all state updates on rising edge.
REQ-002 Resetn  in  1  asynchronous, active-low reset.
REQ-003 Run  in  1  start/continue instruction execution.
REQ-004 IR  in  9  current instruction, registered externally: IR[8:6] opcode, IR[5:3] X, IR[2:0] Y.
REQ-005 Gnz  in  1  high when the G (ALU result) register is nonzero.
REQ-006 Rin  out  8  register write enables; bit i enables Ri; R7 is the PC.
REQ-007 Rout  out  8  bus select; bit i drives Ri onto the bus.
REQ-008 Gout, DINout  out  1 each  drive G or memory data-in onto the bus.
REQ-009 Ain, Gin, IRin, ADDRin, DOUTin  out  1 each  load the A, G, IR, address and data-out registers.
REQ-010 PCincr  out  1  increment R7.
REQ-011 W_D  out  1  memory write strobe.
REQ-012 AddSub  out  1  ALU mode: 0 = add, 1 = subtract.
REQ-013 Done  out  1  high in the final cycle of each instruction.

Function
REQ-014 States SHALL be IDLE, FETCH, WAIT, LOADIR, EX1, EX2, EX3, plus HALT when ILLEGAL_TRAP_EN is defined.
REQ-015 IDLE: all outputs 0; next state is FETCH if Run=1, else IDLE.
REQ-016 FETCH: Rout[7], ADDRin and PCincr asserted; next state WAIT.
REQ-017 WAIT: no outputs (one-cycle memory latency); next state LOADIR.
REQ-018 LOADIR: IRin asserted; next state EX1.
REQ-019 Opcode 000 mv: EX1 asserts Rout[Y], Rin[X], Done.
REQ-020 Opcode 001 mvi: EX1 asserts Rout[7], ADDRin, PCincr; EX2 is a wait cycle; EX3 asserts DINout, Rin[X], Done.
REQ-021 Opcodes 010 add / 011 sub: EX1 asserts Rout[X], Ain; EX2 asserts Rout[Y], Gin, with AddSub = IR[6]; EX3 asserts Gout, Rin[X], Done.
REQ-022 Opcode 100 ld: EX1 asserts Rout[Y], ADDRin; EX2 is a wait cycle; EX3 asserts DINout, Rin[X], Done.
REQ-023 Opcode 101 st: EX1 asserts Rout[Y], ADDRin; EX2 asserts Rout[X], DOUTin, W_D, Done.
REQ-024 Opcode 110 mvnz: EX1 asserts Done; Rout[Y] and Rin[X] are asserted only if Gnz=1.
REQ-025 Opcode 111: handled as specified under Configuration.
REQ-026 After the Done cycle, next state SHALL be FETCH if Run=1, else IDLE.
REQ-027 Run=0 mid-instruction SHALL NOT abort the instruction; Run is sampled only in IDLE and in the Done cycle.
REQ-028 At most one of Rout[7:0], Gout and DINout SHALL be high in any cycle.
REQ-029 Outputs SHALL be combinational functions of state, IR and Gnz only, with no glitch-relevant paths from Run.
REQ-030 Cycle counts from FETCH through Done: mv/mvnz = 4, st = 5, mvi/add/sub/ld = 6.
REQ-031 X = 7 or Y = 7 SHALL be legal: writing R7 redirects the PC, and reading R7 gives the incremented PC.

Reset
REQ-032 Resetn=0 SHALL force state to IDLE asynchronously; all outputs and Illegal SHALL be 0 while reset is held.
REQ-033 Reset asserted mid-instruction SHALL abandon the instruction with no further strobes.
REQ-034 After Resetn rises, the first FETCH SHALL occur one cycle after Run=1 is sampled.

Configuration
REQ-035 Macro ILLEGAL_TRAP_EN SHALL select how opcode 111 is handled.
REQ-036 With ILLEGAL_TRAP_EN defined: an extra output Illegal (1 bit) exists; opcode 111 in EX1 sets Illegal (sticky) and enters HALT; HALT drives all outputs 0 except Illegal, ignores Run, and exits only on reset.
REQ-037 Without ILLEGAL_TRAP_EN: no Illegal port; opcode 111 is a NOP that asserts only Done in EX1.

Verification
REQ-038 Reset, then Run=1, then IR=9'b000_011_101 (mv R3,R5): the bench SHALL check FETCH/WAIT/LOADIR strobes, then EX1 with Rout=8'h20, Rin=8'h08, Done=1 in cycle 4.
REQ-039 IR=9'b011_001_010 (sub R1,R2): EX1 Rout=8'h02, Ain=1; EX2 Rout=8'h04, Gin=1, AddSub=1; EX3 Gout=1, Rin=8'h02, Done=1.
REQ-040 IR=9'b110_000_001 with Gnz=0: EX1 Done=1, Rin=0, Rout=0; repeat with Gnz=1: Rout=8'h02, Rin=8'h01.
REQ-041 st R4,[R6]: EX2 Rout=8'h10, DOUTin=1, W_D=1, Done=1; drop Run during EX1: the instruction completes, then IDLE with all outputs 0.
REQ-042 Drive Resetn=0 during EX2 of an add: outputs 0 immediately and IDLE; Run=1 after release yields FETCH.
REQ-043 Opcode 111: with ILLEGAL_TRAP_EN, Illegal=1 and the block stays in HALT for 10 cycles with Run=1; without it, Done=1 in EX1 and the next FETCH follows.
